// File: rtl/seven_segment_4_digits_capture_if.sv
// Pin bundle between a 4-digit multiplexed seven-segment display driver and
// the capture block that reconstructs the displayed value from its pins.
interface seven_segment_4_digits_capture_if;
    logic [7:0]  abcdefgh;
    logic [3:0]  digit;
    logic [15:0] number;
    logic [3:0]  dp;
    logic        valid;
    logic        error;
    logic        lost;

    modport master (
        output abcdefgh,
        output digit,
        input  number,
        input  dp,
        input  valid,
        input  error,
        input  lost
    );

    modport slave (
        input  abcdefgh,
        input  digit,
        output number,
        output dp,
        output valid,
        output error,
        output lost
    );
endinterface

// File: rtl/seven_segment_4_digits_capture.sv
// Receive side of the 4-digit multiplexed seven-segment display. Synchronizes
// the segment/strobe pins, waits for each strobe dwell to settle, samples it
// exactly once, decodes the glyph and assembles a 16-bit value plus decimal
// points. A frame is published only after all four digits decoded cleanly.
module seven_segment_4_digits_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE      = 4,
    parameter int TIMEOUT_W   = 20
) (
    input logic                             clock,
    input logic                             reset,
    seven_segment_4_digits_capture_if.slave bus
);
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE - 1);

    logic [11:0]          sync_pipe [SYNC_STAGES];
    logic [11:0]          word;
    logic [11:0]          held;
    logic [CNT_W-1:0]     settle_cnt;
    logic                 sampled;
    logic                 changed;
    logic                 sample_evt;
    logic [TIMEOUT_W-1:0] idle_cnt;
    logic                 idle_full;
    logic [3:0]           strobe;
    logic [3:0]           sel;
    logic [3:0]           mask;
    logic                 blank;
    logic                 one_cold;
    logic [4:0]           decoded;
    logic                 good;
    logic                 bad;
    logic                 frame_done;
    logic [15:0]          shadow_num;
    logic [15:0]          shadow_num_next;
    logic [3:0]           shadow_dp;
    logic [3:0]           shadow_dp_next;
    logic [15:0]          captured_number;
    logic [3:0]           captured_dp;
    logic                 valid_pulse;
    logic                 error_pulse;
    logic                 lost_flag;

    // Glyph lookup for segments a..g (active-low); bit 4 flags a known glyph.
    function automatic logic [4:0] decode_segments(input logic [6:0] seg);
        logic [4:0] result;
        case (seg)
            7'b0000001: result = {1'b1, 4'h0};
            7'b1001111: result = {1'b1, 4'h1};
            7'b0010010: result = {1'b1, 4'h2};
            7'b0000110: result = {1'b1, 4'h3};
            7'b1001100: result = {1'b1, 4'h4};
            7'b0100100: result = {1'b1, 4'h5};
            7'b0100000: result = {1'b1, 4'h6};
            7'b0001111: result = {1'b1, 4'h7};
            7'b0000000: result = {1'b1, 4'h8};
            7'b0001100: result = {1'b1, 4'h9};
            7'b0001000: result = {1'b1, 4'hA};
            7'b1100000: result = {1'b1, 4'hB};
            7'b0110001: result = {1'b1, 4'hC};
            7'b1000010: result = {1'b1, 4'hD};
            7'b0110000: result = {1'b1, 4'hE};
            7'b0111000: result = {1'b1, 4'hF};
            default:    result = 5'b0_0000;
        endcase
        return result;
    endfunction

    // Synchronizer chain; resets to the idle (all pins high) pattern so a
    // released reset never looks like a multi-strobe fault.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_pipe[i] <= '1;
            end
        end else begin
            sync_pipe[0] <= {bus.abcdefgh, bus.digit};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_pipe[i] <= sync_pipe[i-1];
            end
        end
    end

    // Classify the synced word: dwell change, sample point, glyph and strobe.
    always_comb begin
        word       = sync_pipe[SYNC_STAGES-1];
        changed    = (word != held);
        sample_evt = !changed && (settle_cnt == CNT_MAX) && !sampled;
        strobe     = word[3:0];
        sel        = ~strobe;
        blank      = (strobe == 4'b1111);
        one_cold   = ($countones(sel) == 1);
        decoded    = decode_segments(word[11:5]);
        good       = sample_evt && one_cold && decoded[4];
        bad        = sample_evt && !blank && !(one_cold && decoded[4]);
        frame_done = good && ((mask | sel) == 4'b1111);
        idle_full  = &idle_cnt;
    end

    // Shadow value with the currently strobed digit's nibble and dp merged in.
    always_comb begin
        shadow_num_next = shadow_num;
        shadow_dp_next  = shadow_dp;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                shadow_num_next[i*4 +: 4] = decoded[3:0];
                shadow_dp_next[i]         = ~word[4];
            end
        end
    end

    // Dwell tracker: restart on any change, fire one sample per settled dwell.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            held       <= '1;
            settle_cnt <= '0;
            sampled    <= 1'b0;
        end else if (changed) begin
            held       <= word;
            settle_cnt <= '0;
            sampled    <= 1'b0;
        end else begin
            if (settle_cnt != CNT_MAX) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
            if (sample_evt) begin
                sampled <= 1'b1;
            end
        end
    end

    // Idle counter: time since the last sample, saturating at all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (sample_evt) begin
            idle_cnt <= '0;
        end else if (!idle_full) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Frame assembly and publication; a bad sample or a lost display drops
    // the partial frame, the published value only changes on a full frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mask            <= 4'b0000;
            shadow_num      <= '0;
            shadow_dp       <= '0;
            captured_number <= '0;
            captured_dp     <= '0;
            valid_pulse     <= 1'b0;
            error_pulse     <= 1'b0;
            lost_flag       <= 1'b1;
        end else begin
            valid_pulse <= 1'b0;
            error_pulse <= 1'b0;
            if (bad) begin
                error_pulse <= 1'b1;
                mask        <= 4'b0000;
            end else if (good) begin
                shadow_num <= shadow_num_next;
                shadow_dp  <= shadow_dp_next;
                if (frame_done) begin
                    captured_number <= shadow_num_next;
                    captured_dp     <= shadow_dp_next;
                    valid_pulse     <= 1'b1;
                    mask            <= 4'b0000;
                end else begin
                    mask <= mask | sel;
                end
            end else if (idle_full) begin
                mask <= 4'b0000;
            end

            if (frame_done) begin
                lost_flag <= 1'b0;
            end else if (idle_full) begin
                lost_flag <= 1'b1;
            end
        end
    end

    assign bus.number = captured_number;
    assign bus.dp     = captured_dp;
    assign bus.valid  = valid_pulse;
    assign bus.error  = error_pulse;
    assign bus.lost   = lost_flag;
endmodule

// File: tb/tb_seven_segment_4_digits_capture.sv
// Bench for seven_segment_4_digits_capture: drives multiplexed display pins
// and compares every output pulse against a frame-level reference model.
module tb_seven_segment_4_digits_capture;
    localparam int SYNC_STAGES = 2;
    localparam int SETTLE      = 4;
    // Short idle timeout so the display-lost condition is reachable quickly.
    localparam int TIMEOUT_W   = 10;
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] DIG_OFF = 4'hF;

    typedef struct {
        int          at;
        bit          err;
        logic [15:0] num;
        logic [3:0]  dpv;
    } ev_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   valid_seen = 0;
    int   error_seen = 0;

    logic [6:0]  seg_tab [16];
    logic [15:0] sh_num;
    logic [3:0]  sh_dp;
    logic [3:0]  m_mask;
    logic [11:0] prev_pins;
    int          run;
    ev_t         expq [$];

    seven_segment_4_digits_capture_if bus();

    seven_segment_4_digits_capture #(
        .SYNC_STAGES(SYNC_STAGES),
        .SETTLE(SETTLE),
        .TIMEOUT_W(TIMEOUT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] seg_of(input int n, input bit dp_on);
        return {seg_tab[n], ~dp_on};
    endfunction

    function automatic logic [3:0] dig_of(input int i);
        logic [3:0] d;
        d    = 4'b1111;
        d[i] = 1'b0;
        return d;
    endfunction

    // Reference: apply the display rules to one sampled dwell.
    task automatic model_sample(input logic [7:0] seg, input logic [3:0] dig, input int at);
        int  zeros;
        int  idx;
        int  nib;
        ev_t e;
        zeros = 0;
        idx   = 0;
        for (int i = 0; i < 4; i++) begin
            if (!dig[i]) begin
                zeros++;
                idx = i;
            end
        end
        if (zeros == 0) return;
        nib = -1;
        for (int n = 0; n < 16; n++) begin
            if (seg_tab[n] == seg[7:1]) nib = n;
        end
        e.at  = at;
        e.err = 1'b0;
        e.num = '0;
        e.dpv = '0;
        if (zeros > 1 || nib < 0) begin
            e.err  = 1'b1;
            m_mask = 4'b0000;
            expq.push_back(e);
            return;
        end
        sh_num[idx*4 +: 4] = 4'(nib);
        sh_dp[idx]         = ~seg[0];
        m_mask[idx]        = 1'b1;
        if (m_mask == 4'b1111) begin
            e.num  = sh_num;
            e.dpv  = sh_dp;
            m_mask = 4'b0000;
            expq.push_back(e);
        end
    endtask

    // One clock: check this cycle's outputs, then drive the next pin value.
    task automatic step(input logic [7:0] seg, input logic [3:0] dig);
        ev_t e;
        @(negedge clock);
        if (expq.size() > 0 && expq[0].at < cyc) begin
            e = expq.pop_front();
            check_eq("event_cycle", cyc, e.at);
        end
        if (expq.size() > 0 && expq[0].at == cyc) begin
            e = expq.pop_front();
            check_eq(e.err ? "error_pulse" : "valid_pulse", {bus.valid, bus.error},
                     e.err ? 32'd1 : 32'd2);
            if (!e.err) begin
                check_eq("number", bus.number, e.num);
                check_eq("dp", bus.dp, e.dpv);
            end
        end else begin
            check_eq("no_pulse", {bus.valid, bus.error}, 0);
        end
        if (bus.valid) valid_seen++;
        if (bus.error) error_seen++;
        bus.abcdefgh = seg;
        bus.digit    = dig;
        if ({seg, dig} == prev_pins) run++;
        else run = 1;
        prev_pins = {seg, dig};
        if (run == SETTLE + 1) model_sample(seg, dig, cyc + 1 + SYNC_STAGES);
    endtask

    task automatic dwell(input logic [7:0] seg, input logic [3:0] dig, input int len);
        repeat (len) step(seg, dig);
    endtask

    task automatic frame(input logic [15:0] val, input logic [3:0] dps, input int len);
        for (int i = 0; i < 4; i++) begin
            dwell(seg_of(int'(val[i*4 +: 4]), dps[i]), dig_of(i), len);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset        = 1'b1;
        bus.abcdefgh = SEG_OFF;
        bus.digit    = DIG_OFF;
        repeat (3) @(negedge clock);
        check_eq("reset_number", bus.number, 16'h0000);
        check_eq("reset_dp", bus.dp, 4'h0);
        check_eq("reset_valid", bus.valid, 1'b0);
        check_eq("reset_error", bus.error, 1'b0);
        check_eq("reset_lost", bus.lost, 1'b1);
        reset     = 1'b0;
        m_mask    = 4'b0000;
        sh_num    = '0;
        sh_dp     = '0;
        expq.delete();
        prev_pins = {SEG_OFF, DIG_OFF};
        run       = 0;
    endtask

    initial begin
        int          vs;
        int          es;
        int          len;
        logic [15:0] val;
        logic [3:0]  dps;
        logic [7:0]  seg;
        logic [3:0]  dig;

        seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        bus.abcdefgh = SEG_OFF;
        bus.digit    = DIG_OFF;
        sh_num    = '0;
        sh_dp     = '0;
        m_mask    = '0;
        prev_pins = {SEG_OFF, DIG_OFF};
        run       = 0;

        // Reset and idle display.
        do_reset();
        dwell(SEG_OFF, DIG_OFF, 1000);
        check_eq("idle_lost", bus.lost, 1'b1);
        check_eq("idle_valids", valid_seen, 0);
        check_eq("idle_errors", error_seen, 0);

        // Basic frame 0x1234 with dp on digit 2.
        frame(16'h1234, 4'b0100, 20);
        dwell(SEG_OFF, DIG_OFF, 10);
        check_eq("f1234_number", bus.number, 16'h1234);
        check_eq("f1234_dp", bus.dp, 4'b0100);
        check_eq("f1234_lost", bus.lost, 1'b0);
        check_eq("f1234_valids", valid_seen, 1);

        // All sixteen glyphs across four frames.
        es = error_seen;
        for (int k = 0; k < 4; k++) begin
            val = '0;
            for (int i = 0; i < 4; i++) val[i*4 +: 4] = 4'((4 * k + i) % 16);
            dps = 4'($urandom_range(0, 15));
            frame(val, dps, $urandom_range(5, 15));
            dwell(SEG_OFF, DIG_OFF, 12);
            check_eq("sweep_number", bus.number, val);
            check_eq("sweep_dp", bus.dp, dps);
        end
        check_eq("sweep_errors", error_seen - es, 0);

        // Bad glyph, then a multi-strobe, then a clean 0xBEEF frame.
        vs = valid_seen;
        es = error_seen;
        dwell(SEG_OFF, dig_of(1), 10);
        dwell(seg_of(0, 1'b0), 4'b0011, 10);
        dwell(SEG_OFF, DIG_OFF, 10);
        check_eq("bad_errors", error_seen - es, 2);
        check_eq("bad_valids", valid_seen - vs, 0);
        frame(16'hBEEF, 4'b0000, 10);
        dwell(SEG_OFF, DIG_OFF, 10);
        check_eq("beef_number", bus.number, 16'hBEEF);
        check_eq("beef_valids", valid_seen - vs, 1);

        // Short glitches on segments and strobe must not be sampled.
        vs = valid_seen;
        es = error_seen;
        dwell(seg_of(6, 1'b0), dig_of(0), 6);
        dwell(SEG_OFF, dig_of(0), 2);
        dwell(seg_of(6, 1'b0), dig_of(0), 8);
        dwell(seg_of(9, 1'b1), dig_of(1), 6);
        dwell(seg_of(9, 1'b1), dig_of(2), 1);
        dwell(seg_of(9, 1'b1), dig_of(1), 8);
        dwell(seg_of(13, 1'b0), dig_of(2), 10);
        dwell(seg_of(7, 1'b0), dig_of(3), 10);
        dwell(SEG_OFF, DIG_OFF, 10);
        check_eq("glitch_number", bus.number, 16'h7D96);
        check_eq("glitch_dp", bus.dp, 4'b0010);
        check_eq("glitch_errors", error_seen - es, 0);
        check_eq("glitch_valids", valid_seen - vs, 1);

        // Random dwells of random length, glyphs and strobes.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 99) < 85) seg = seg_of($urandom_range(0, 15), 1'($urandom_range(0, 1)));
            else seg = 8'($urandom);
            case ($urandom_range(0, 9))
                0: dig = DIG_OFF;
                1: begin
                    dig = 4'($urandom_range(0, 15));
                    while ($countones(~dig) < 2) dig = 4'($urandom_range(0, 15));
                end
                default: dig = dig_of($urandom_range(0, 3));
            endcase
            len = $urandom_range(1, 12);
            dwell(seg, dig, len);
        end
        dwell(SEG_OFF, DIG_OFF, 20);
        check_eq("random_drained", expq.size(), 0);

        // Reset mid-frame, then a full frame delivered in a different order.
        dwell(seg_of(7, 1'b0), dig_of(0), 10);
        dwell(seg_of(7, 1'b0), dig_of(1), 10);
        dwell(SEG_OFF, DIG_OFF, 10);
        do_reset();
        vs = valid_seen;
        dwell(SEG_OFF, DIG_OFF, 5);
        dwell(seg_of(5, 1'b0), dig_of(2), 10);
        dwell(seg_of(10, 1'b0), dig_of(3), 10);
        dwell(seg_of(3, 1'b0), dig_of(0), 10);
        dwell(seg_of(12, 1'b0), dig_of(1), 10);
        dwell(seg_of(12, 1'b0), dig_of(1), 900);
        check_eq("a5c3_number", bus.number, 16'hA5C3);
        check_eq("a5c3_valids", valid_seen - vs, 1);
        check_eq("a5c3_lost", bus.lost, 1'b0);

        // Static pins: the display is declared lost, the value is kept.
        dwell(seg_of(12, 1'b0), dig_of(1), 300);
        check_eq("lost_flag", bus.lost, 1'b1);
        check_eq("lost_number", bus.number, 16'hA5C3);
        check_eq("lost_valids", valid_seen - vs, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
